pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It watches the ID stage operands, the ID/EX stage register outputs, the MEM-stage branch resolution and the data-memory handshake. Each cycle it drives the write-enable and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It also keeps stall and flush performance counters, and holds a memory-timeout watchdog with a sticky error state.

---
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage MIPS pipeline
// Resolves memory freeze, taken-branch flush and load-use stalls; counts stalls/flushes.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             mem_branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             exmem_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               mem_err_q, mem_err_d;

  logic freeze, branch, load_use, timeout;

  always_comb begin
    freeze   = ((state_q == RUN) && mem_req_i && !mem_ready_i) ||
               ((state_q == MEMWAIT) && !mem_ready_i);
    timeout  = freeze && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));
    branch   = !freeze && (state_q != ERR) && mem_branch_taken_i;
    // A load into r0 never produces a value worth waiting for.
    load_use = !freeze && !branch && (state_q != ERR) && ex_memread_i && (ex_rt_i != 5'd0) &&
               ((id_use_rs_i && (id_rs_i == ex_rt_i)) || (id_use_rt_i && (id_rt_i == ex_rt_i)));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (timeout) state_d = ERR;
               else if (freeze) state_d = MEMWAIT;
      MEMWAIT: if (timeout) state_d = ERR;
               else if (mem_ready_i) state_d = RUN;
      default: state_d = ERR;
    endcase
    wait_cnt_d  = freeze ? wait_cnt_q + WAIT_W'(1) : '0;
    stall_cnt_d = (freeze || load_use) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = branch ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    mem_err_d   = (state_d == ERR);
  end

  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    idex_write_o   = 1'b1;
    exmem_write_o  = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    memwb_bubble_o = 1'b0;
    if (!rst_ni) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if ((state_q == ERR) || freeze) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (branch) begin
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
    end else if (load_use) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      idex_flush_o   = 1'b1;
    end
  end

  assign mem_err_o   = mem_err_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  id_rs_i, id_rt_i, ex_rt_i;
  logic        id_use_rs_i, id_use_rt_i, ex_memread_i;
  logic        mem_branch_taken_i, mem_req_i, mem_ready_i;
  logic        pc_write_o, ifid_write_o, idex_write_o, exmem_write_o;
  logic        ifid_flush_o, idex_flush_o, memwb_bubble_o, mem_err_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_use_rs_i(id_use_rs_i), .id_use_rt_i(id_use_rt_i),
    .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
    .mem_branch_taken_i(mem_branch_taken_i),
    .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .idex_write_o(idex_write_o), .exmem_write_o(exmem_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .memwb_bubble_o(memwb_bubble_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Packed control vector: {pc, ifid, idex, exmem, ifid_flush, idex_flush, memwb_bubble}
  function automatic logic [6:0] ctl();
    return {pc_write_o, ifid_write_o, idex_write_o, exmem_write_o,
            ifid_flush_o, idex_flush_o, memwb_bubble_o};
  endfunction

  localparam logic [6:0] CTL_NORMAL = 7'b1111_000;
  localparam logic [6:0] CTL_FREEZE = 7'b0000_001;
  localparam logic [6:0] CTL_RESET  = 7'b0000_111;
  localparam logic [6:0] CTL_BRANCH = 7'b1111_110;
  localparam logic [6:0] CTL_LOAD   = 7'b0011_010;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs_i = 5'd0; id_rt_i = 5'd0; ex_rt_i = 5'd0;
    id_use_rs_i = 1'b0; id_use_rt_i = 1'b0; ex_memread_i = 1'b0;
    mem_branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    #3;
    total++;
    if (ctl() !== CTL_RESET) begin
      bad++; $display("FAIL reset_ctl got=%b want=%b", ctl(), CTL_RESET);
    end
    total++;
    if ({mem_err_o, stall_cnt_o, flush_cnt_o} !== 65'd0) begin
      bad++; $display("FAIL reset_regs err=%b stall=%0d flush=%0d want 0/0/0", mem_err_o, stall_cnt_o, flush_cnt_o);
    end
    cyc();
    rst_ni = 1'b1;
    cyc();
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL post_reset_ctl got=%b want=%b", ctl(), CTL_NORMAL);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; id_use_rs_i = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_LOAD) begin
      bad++; $display("FAIL load_use_ctl got=%b want=%b", ctl(), CTL_LOAD);
    end
    cyc();
    total++;
    if (stall_cnt_o !== 32'd1) begin
      bad++; $display("FAIL load_use_stall got=%0d want=1", stall_cnt_o);
    end
    ex_memread_i = 1'b0;
    #1;
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL load_use_release got=%b want=%b", ctl(), CTL_NORMAL);
    end
    cyc();
    // Match via rt also stalls.
    idle_inputs();
    ex_memread_i = 1'b1; ex_rt_i = 5'd9; id_rt_i = 5'd9; id_use_rt_i = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_LOAD) begin
      bad++; $display("FAIL load_use_rt_ctl got=%b want=%b", ctl(), CTL_LOAD);
    end
    cyc();
    total++;
    if (stall_cnt_o !== 32'd2) begin
      bad++; $display("FAIL load_use_rt_stall got=%0d want=2", stall_cnt_o);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd0; id_rs_i = 5'd0; id_use_rs_i = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL r0_ctl got=%b want=%b", ctl(), CTL_NORMAL);
    end
    cyc();
    idle_inputs();
    ex_memread_i = 1'b1; ex_rt_i = 5'd7; id_rt_i = 5'd7; id_use_rt_i = 1'b0;
    #1;
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL unused_rt_ctl got=%b want=%b", ctl(), CTL_NORMAL);
    end
    cyc();
    total++;
    if (stall_cnt_o !== 32'd0) begin
      bad++; $display("FAIL no_hazard_stall got=%0d want=0", stall_cnt_o);
    end
  endtask

  task automatic test_branch_over_load();
    do_reset();
    ex_memread_i = 1'b1; ex_rt_i = 5'd5; id_rs_i = 5'd5; id_use_rs_i = 1'b1;
    mem_branch_taken_i = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_BRANCH) begin
      bad++; $display("FAIL branch_ctl got=%b want=%b", ctl(), CTL_BRANCH);
    end
    cyc();
    total++;
    if ({flush_cnt_o, stall_cnt_o} !== {32'd1, 32'd0}) begin
      bad++; $display("FAIL branch_cnt flush=%0d stall=%0d want 1/0", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    // Same-cycle ready: no freeze.
    mem_req_i = 1'b1; mem_ready_i = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL mem_fast_ctl got=%b want=%b", ctl(), CTL_NORMAL);
    end
    cyc();
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // From the second cycle on, MEMWAIT must freeze even without mem_req.
      if (i > 0) mem_req_i = 1'b0;
      mem_branch_taken_i = (i == 2);
      #1;
      total++;
      if (ctl() !== CTL_FREEZE) begin
        bad++; $display("FAIL mem_wait_ctl cycle=%0d got=%b want=%b", i, ctl(), CTL_FREEZE);
      end
      cyc();
    end
    mem_ready_i = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_BRANCH) begin
      bad++; $display("FAIL mem_done_ctl got=%b want=%b", ctl(), CTL_BRANCH);
    end
    cyc();
    mem_branch_taken_i = 1'b0; mem_ready_i = 1'b0; mem_req_i = 1'b0;
    #1;
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL mem_back_run_ctl got=%b want=%b", ctl(), CTL_NORMAL);
    end
    total++;
    if ({stall_cnt_o, flush_cnt_o} !== {32'd3, 32'd1}) begin
      bad++; $display("FAIL mem_wait_cnt stall=%0d flush=%0d want 3/1", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++;
      if ({ctl(), mem_err_o} !== {CTL_FREEZE, 1'b0}) begin
        bad++; $display("FAIL timeout_frozen cycle=%0d got=%b err=%b want=%b err=0", i, ctl(), mem_err_o, CTL_FREEZE);
      end
      cyc();
    end
    total++;
    if ({mem_err_o, stall_cnt_o} !== {1'b1, 32'd4}) begin
      bad++; $display("FAIL timeout_err err=%b stall=%0d want 1/4", mem_err_o, stall_cnt_o);
    end
    mem_ready_i = 1'b1; mem_branch_taken_i = 1'b1;
    ex_memread_i = 1'b1; ex_rt_i = 5'd3; id_rs_i = 5'd3; id_use_rs_i = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_FREEZE) begin
      bad++; $display("FAIL err_ctl got=%b want=%b", ctl(), CTL_FREEZE);
    end
    cyc();
    cyc();
    total++;
    if ({mem_err_o, stall_cnt_o, flush_cnt_o} !== {1'b1, 32'd4, 32'd0}) begin
      bad++; $display("FAIL err_sticky err=%b stall=%0d flush=%0d want 1/4/0", mem_err_o, stall_cnt_o, flush_cnt_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({ctl(), mem_err_o, stall_cnt_o} !== {CTL_RESET, 1'b0, 32'd0}) begin
      bad++; $display("FAIL err_reset ctl=%b err=%b stall=%0d want %b/0/0", ctl(), mem_err_o, stall_cnt_o, CTL_RESET);
    end
    cyc();
    idle_inputs();
    rst_ni = 1'b1;
    #1;
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL err_recover got=%b want=%b", ctl(), CTL_NORMAL);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    mem_req_i = 1'b1; mem_ready_i = 1'b0;
    cyc();
    cyc();
    total++;
    if (stall_cnt_o !== 32'd2) begin
      bad++; $display("FAIL async_pre_stall got=%0d want=2", stall_cnt_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({ctl(), stall_cnt_o} !== {CTL_RESET, 32'd0}) begin
      bad++; $display("FAIL async_reset ctl=%b stall=%0d want %b/0", ctl(), stall_cnt_o, CTL_RESET);
    end
    #1 rst_ni = 1'b1;
    mem_req_i = 1'b0;
    #1;
    total++;
    if (ctl() !== CTL_NORMAL) begin
      bad++; $display("FAIL async_back_run got=%b want=%b", ctl(), CTL_NORMAL);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_over_load();
    test_mem_wait();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
